// File: rtl/inv_sub_bytes_iter.sv
// =============================================================================
// Module      : inv_sub_bytes_iter
// Description : Iterative AES InvSubBytes over a 128-bit state word, one
//               32-bit column per cycle; INV_SUB_BYTES_FULL_WIDTH_EN selects
//               a single-cycle, 16-lookup datapath instead.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module inv_sub_bytes_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] C_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [127:0]  in_buf_q, in_buf_d;
    logic [127:0]  result_q, result_d;
    logic          out_valid_q, out_valid_d;

`ifdef INV_SUB_BYTES_FULL_WIDTH_EN
    logic [127:0]  w_full_sub;

    for (genvar b = 0; b < 16; b++) begin : g_lut_full
        assign w_full_sub[127-8*b -: 8] = C_INV_SBOX[in_buf_q[127-8*b -: 8]];
    end
`else
    logic [31:0]   w_col_in;
    logic [31:0]   w_col_sub;

    always_comb begin
        w_col_in = 32'h0;
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) begin
                w_col_in = in_buf_q[127-32*c -: 32];
            end
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_lut_col
        assign w_col_sub[31-8*b -: 8] = C_INV_SBOX[w_col_in[31-8*b -: 8]];
    end
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        in_buf_d    = in_buf_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_buf_d = in_data;
                    col_d    = 2'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
`ifdef INV_SUB_BYTES_FULL_WIDTH_EN
                result_d    = w_full_sub;
                state_d     = DONE;
                out_valid_d = 1'b1;
`else
                for (int c = 0; c < 4; c++) begin
                    if (col_q == 2'(c)) begin
                        result_d[127-32*c -: 32] = w_col_sub;
                    end
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                col_d       = 2'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            in_buf_q    <= 128'h0;
            result_q    <= 128'h0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            in_buf_q    <= in_buf_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Reset masks the handshake outputs even before the first reset edge.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = result_q;

endmodule

`default_nettype wire

// File: doc/inv_sub_bytes_iter.md
INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 The block SHALL have a single clock, `clk`, and a synchronous active-high reset, `rst`, sampled on the rising edge of `clk`.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `in_valid`: input, 1 bit; producer has a state word on `in_data`.
REQ-005 Port `in_ready`: output, 1 bit; block accepts a word this cycle.
REQ-006 Port `in_data`: input, 128 bits; state word, byte 0 = [127:120], byte 15 = [7:0].
REQ-007 Port `out_valid`: output, 1 bit; `out_data` holds a completed result.
REQ-008 Port `out_ready`: input, 1 bit; consumer takes the result.
REQ-009 Port `out_data`: output, 128 bits; the inverse-substituted word.
REQ-010 Port `busy`: output, 1 bit; high while the FSM is not in IDLE.

Function
REQ-011 For every byte i, the block SHALL compute out byte i = InvSbox(in byte i) per FIPS-197 Fig. 14, so that it undoes the forward SubBytes stage byte-for-byte.
REQ-012 The InvSbox table SHALL be a 256x8 combinational lookup, instantiated once per byte processed per cycle.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE, encoded in 2 bits; the fourth code SHALL go to IDLE.
REQ-014 `in_ready` SHALL be 1 only in IDLE with `rst` low; it is combinational from state.
REQ-015 A transfer SHALL occur on a rising edge where `in_valid` and `in_ready` are both 1; the block then latches `in_data` into the input buffer, clears column counter `col` to 0, and moves IDLE -> RUN.
REQ-016 In RUN, default build, each edge SHALL substitute column `col` (bits [127-32*col -: 32]) through 4 lookups, write the result into the same slice of the result register, and increment `col` (2 bits).
REQ-017 On the edge with `col`==3, the FSM SHALL move RUN -> DONE and set `out_valid`=1; `col` wraps to 0.
REQ-018 Latency SHALL be 4 edges from input transfer to `out_valid`=1, i.e. `out_valid` rises 4 cycles after acceptance.
REQ-019 In DONE, `out_data` and `out_valid` SHALL hold stable until `out_valid` and `out_ready` are both 1 on an edge; then `out_valid`=0 and the FSM moves DONE -> IDLE.
REQ-020 `in_ready` SHALL be 0 in RUN and DONE; there is no overlap, and the next word is accepted no earlier than the cycle after the output handshake.
REQ-021 `out_data` SHALL retain its last result after the handshake and SHALL change only on RUN writes.
REQ-022 `in_valid` and `in_data` changes during RUN or DONE SHALL be ignored.
REQ-023 `out_ready` asserted while `out_valid`=0 SHALL have no effect.
REQ-024 Throughput SHALL be one word per 6 cycles with `out_ready` held at 1.

Reset
REQ-025 When `rst`=1 on an edge, the block SHALL set state=IDLE, `col`=0, `out_valid`=0, `out_data`=128'h0 and the input buffer to 0.
REQ-026 While `rst`=1, `in_ready`=0 and `busy`=0.
REQ-027 A reset during RUN or DONE SHALL abort the word, discard any partial result, and raise `in_ready` in the first cycle after `rst` falls.
REQ-028 `rst` SHALL take priority over all simultaneous handshakes.

Configuration
REQ-029 Macro `INV_SUB_BYTES_FULL_WIDTH_EN`: when defined, the block SHALL use 16 lookups and RUN SHALL last one edge, writing all 16 bytes and moving directly to DONE, so the latency is 1 edge and the throughput is one word per 3 cycles.
REQ-030 When `INV_SUB_BYTES_FULL_WIDTH_EN` is undefined, the block SHALL use the 4-lookup, 4-edge behaviour in REQ-016 to REQ-018; the port list SHALL be identical in both builds.

Verification
REQ-031 Input 128'h63636363_63636363_63636363_63636363 -> out_data 128'h0, out_valid rising 4 cycles after acceptance (1 cycle with the macro).
REQ-032 Input 128'h7C00ED16_7C00ED16_7C00ED16_7C00ED16 -> out_data 128'h015253FF_015253FF_015253FF_015253FF.
REQ-033 Backpressure: `out_ready`=0 for 10 cycles in DONE -> out_data and out_valid stay stable, in_ready=0, busy=1; `out_ready`=1 -> one handshake, then in_ready=1 in the next cycle.
REQ-034 Reset mid-RUN: assert `rst` at `col`==2 -> the next cycle shows out_valid=0 and out_data=0; after `rst` falls, in_ready=1 and a new word completes correctly.
REQ-035 Back-to-back: `in_valid` held at 1 with two distinct words and `out_ready`=1 -> the second word is accepted exactly 1 cycle after the first output handshake, and both results match a software InvSbox model.
REQ-036 Round trip: 1000 random words passed through the forward SubBytes model, then this block -> the outputs equal the original words.
